// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1/8N2 serialiser, LSB first, with a sticky
// completion flag that the controller acknowledges explicitly.
module uart_transmitter #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_data,
  input  logic [7:0] data,
  input  logic       disable_data_interrupt,
  output logic       tx,
  output logic       busy,
  output logic       enable_data_interrupt
);

  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W     = $clog2(STOP_CLKS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t         state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           stop_done;

  assign stop_done = (state == STOP) && (cnt == STOP_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= IDLE;
      cnt                   <= '0;
      bit_idx               <= '0;
      shift                 <= '0;
      tx                    <= 1'b1;
      busy                  <= 1'b0;
      enable_data_interrupt <= 1'b0;
    end else begin
      // completion wins over a coincident acknowledge
      if (stop_done)
        enable_data_interrupt <= 1'b1;
      else if (disable_data_interrupt)
        enable_data_interrupt <= 1'b0;

      unique case (state)
        IDLE: begin
          if (send_data) begin
            shift <= data;
            cnt   <= '0;
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (stop_done) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            tx    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Transmit-side counterpart of the UART receiver. Serialises one byte per request onto `tx` as 8N1 (or 8N2) frames, LSB first.
- Uses the same interrupt-style handshake toward the UART controller: a sticky completion flag that the controller clears explicitly.
- Sits between the UART controller and the `tx` pin; in loopback it drives a receiver's `rx`.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (434), clock cycles per bit. Overridable directly for fast simulation; must be >= 2.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- send_data  input  1  request to send `data`. Sampled only in IDLE.
- data  input  8  byte to transmit. Captured on the accepting edge.
- disable_data_interrupt  input  1  controller acknowledge; clears `enable_data_interrupt`.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress.
- enable_data_interrupt  output  1  sticky flag: a frame has completed.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - tx=1, busy=0, enable_data_interrupt=0
  - FSM=IDLE, baud counter=0, bit index=0, shift register=0
- Reset mid-frame aborts the frame immediately; tx returns to 1 without waiting for a clock.
- FSM states and transitions:
  - IDLE: tx=1, busy=0. An edge with send_data=1 accepts the request: data is captured into the shift register, FSM goes to START, baud counter=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. After each bit, shift right and increment bit index; after bit index 7, go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then back to IDLE.
- Outputs are registered; tx and busy change on the accepting edge.
  - First START cycle is the cycle after acceptance.
  - Frame length is exactly (9+STOP_BITS)*CLKS_PER_BIT cycles of busy=1.
- Baud counter:
  - Width is clog2(STOP_BITS*CLKS_PER_BIT).
  - Counts 0..N-1 and wraps to 0 on every state/bit advance.
  - No drift: each bit lasts exactly CLKS_PER_BIT cycles.
- `data` is ignored after capture; changing it mid-frame has no effect.
- send_data while busy=1 is ignored; no queuing. The controller must wait for busy=0.
- Back-to-back transmission:
  - FSM spends at least one cycle in IDLE after STOP, so send_data held high gives frames separated by exactly 1 cycle of tx=1.
  - That is, acceptance occurs on the first IDLE edge.
- enable_data_interrupt:
  - Set on the edge where STOP completes (same edge busy falls).
  - Held until a cycle with disable_data_interrupt=1, which clears it on the next edge.
  - If set and clear coincide, set wins (flag =1).
  - disable_data_interrupt while the flag is 0 has no effect.
- A new frame may start while enable_data_interrupt is still 1; the flag stays 1 (not double-counted).

Test Plan:
- Reset/idle: hold rst=0 for 5 cycles, then release with send_data=0 for 1000 cycles -> tx=1, busy=0, enable_data_interrupt=0 throughout.
- Single byte 0xA5, CLKS_PER_BIT=434, STOP_BITS=1:
  - tx bit sequence at bit centres is 0,1,0,1,0,0,1,0,1,1.
  - busy high for exactly 4340 cycles.
  - enable_data_interrupt rises on the edge busy falls and stays high until disable_data_interrupt is pulsed for 1 cycle, then is 0 the next cycle.
- Busy rejection, CLKS_PER_BIT=8:
  - Send 0x0F, then pulse send_data with data=0xFF at cycle 20 -> ignored; the line carries only 0x0F (bits 1,1,1,1,0,0,0,0).
  - Change data mid-frame -> no effect on the line.
- Back-to-back with send_data held high, data=0x55 then 0x00, CLKS_PER_BIT=8:
  - Two frames of 80 cycles each, separated by exactly 1 high cycle.
  - Interrupt set/clear collision at the second frame end -> flag remains 1.
- Async reset mid-frame: assert rst=0 during DATA bit 3, between clock edges -> tx=1 and busy=0 immediately; the next request sends a full clean frame.
- Loopback to the UART receiver (same CLKS_PER_BIT), STOP_BITS=2: send 0x3C, 0x00, 0xFF -> the receiver flags each byte via its own data interrupt with data matching, and no framing errors.
